// File: rtl/r5p_ifu_pfq.sv
// R5P instruction fetch unit: sequential prefetch into a DEPTH-entry queue, valid/ready to decode.
// Optional macro R5P_IFU_BYPASS_EN presents a response straight to decode when the queue is empty.
module r5p_ifu_pfq #(
    parameter int unsigned    IAW   = 32,
    parameter int unsigned    IDW   = 32,
    parameter int unsigned    IBW   = IDW/8,
    parameter int unsigned    DEPTH = 2,
    parameter logic [IAW-1:0] PC0   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         if_vld,
    output logic [IAW-1:0]               if_adr,
    input  logic [IBW*8-1:0]             if_rdt,
    input  logic                         if_rdy,
    input  logic                         jmp_vld,
    input  logic [IAW-1:0]               jmp_adr,
    output logic                         id_vld,
    output logic [IAW-1:0]               id_pc,
    output logic [IDW-1:0]               id_ins,
    input  logic                         id_rdy,
    output logic [$clog2(DEPTH+1)-1:0]   cnt
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                 r_run;
    logic                 r_inf;
    logic [IAW-1:0]       r_fpc;
    logic [IAW-1:0]       r_rpc;
    logic [PW-1:0]        r_wp;
    logic [PW-1:0]        r_rp;
    logic [CW-1:0]        r_cnt;
    logic [IAW-1:0]       r_qpc  [DEPTH];
    logic [IDW-1:0]       r_qins [DEPTH];

    logic [IAW-1:0]       w_tgt;
    logic [CW:0]          w_occ;
    logic                 w_space;
    logic                 w_acc;
    logic                 w_empty;
    logic                 w_byp;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_unused;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign w_unused = ^jmp_adr[1:0];
    assign w_tgt    = {jmp_adr[IAW-1:2], 2'b00};

    // Queue space is reserved for the in-flight word before a new request is issued.
    assign w_occ    = {1'b0, r_cnt} + {{CW{1'b0}}, r_inf};
    assign w_space  = w_occ < (CW+1)'(DEPTH);
    assign if_vld   = jmp_vld | (r_run & w_space);
    assign if_adr   = jmp_vld ? w_tgt : r_fpc;
    assign w_acc    = if_vld & if_rdy;
    assign w_empty  = (r_cnt == '0);
    assign cnt      = r_cnt;

`ifdef R5P_IFU_BYPASS_EN
    assign w_byp    = r_inf & w_empty;
`else
    assign w_byp    = 1'b0;
`endif

    assign id_vld   = ~w_empty | w_byp;
    assign id_pc    = w_byp ? r_rpc  : r_qpc[r_rp];
    assign id_ins   = w_byp ? if_rdt : r_qins[r_rp];

    // With fixed latency 1, a word in flight during a redirect lands in that same
    // cycle, so gating the push with the flush is what discards it.
    assign w_push   = r_inf & ~jmp_vld & ~(w_byp & id_rdy);
    assign w_pop    = id_rdy & ~w_empty & ~jmp_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= 1'b0;
            r_inf <= 1'b0;
            r_fpc <= PC0;
            r_rpc <= PC0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            r_run <= 1'b1;
            r_inf <= w_acc;
            if (w_acc) begin
                r_fpc <= if_adr + IAW'(4);
                r_rpc <= if_adr;
            end else if (jmp_vld) begin
                r_fpc <= w_tgt;
            end
            if (jmp_vld) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) r_wp <= nxt(r_wp);
                if (w_pop)  r_rp <= nxt(r_rp);
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + 1'b1;
                    2'b01:   r_cnt <= r_cnt - 1'b1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_qpc[r_wp]  <= r_rpc;
            r_qins[r_wp] <= if_rdt;
        end
    end

endmodule

// File: tb/tb_r5p_ifu_pfq.sv
// Scoreboard bench for r5p_ifu_pfq: bus slave model, occupancy/issue model and in-order check.
module tb_r5p_ifu_pfq;

    localparam int          DEPTH = 2;
    localparam logic [31:0] PC0   = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_vld;
    logic [31:0] if_adr;
    logic [31:0] if_rdt;
    logic        if_rdy;
    logic        jmp_vld;
    logic [31:0] jmp_adr;
    logic        id_vld;
    logic [31:0] id_pc;
    logic [31:0] id_ins;
    logic        id_rdy;
    logic [1:0]  cnt;

    always #5 clk = ~clk;

    r5p_ifu_pfq #(.IAW(32), .IDW(32), .DEPTH(DEPTH), .PC0(PC0)) dut (
        .clk(clk), .rst(rst),
        .if_vld(if_vld), .if_adr(if_adr), .if_rdt(if_rdt), .if_rdy(if_rdy),
        .jmp_vld(jmp_vld), .jmp_adr(jmp_adr),
        .id_vld(id_vld), .id_pc(id_pc), .id_ins(id_ins), .id_rdy(id_rdy),
        .cnt(cnt)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          resp_due;
    logic [31:0] slv_adr;
    logic [31:0] exp_radr;
    logic [31:0] exp_fpc;
    bit          run_m;
    int          cyc_n;
    int          first_acc;
    int          first_id;
    bit          want_vld;
    logic [31:0] want_pc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: called at a negedge, returns at the next negedge.
    task automatic cyc(input bit jv, input logic [31:0] ja, input bit ir, input bit dr);
        int          occ;
        bit          exp_ifv;
        bit          exp_idv;
        logic [31:0] exp_adr;
        ent_t        e;
        jmp_vld = jv;
        jmp_adr = ja;
        if_rdy  = ir;
        id_rdy  = dr;
        occ     = sb.size();
        if_rdt  = resp_due ? mem(slv_adr) : $urandom;
        #1;
        exp_ifv = jv || (run_m && (occ + int'(resp_due) < DEPTH));
`ifdef R5P_IFU_BYPASS_EN
        exp_idv = (occ != 0) || resp_due;
`else
        exp_idv = (occ != 0);
`endif
        chk("if_vld", if_vld, exp_ifv);
        chk("cnt", cnt, occ);
        chk("id_vld", id_vld, exp_idv);
        exp_adr = jv ? {ja[31:2], 2'b00} : exp_fpc;
        if (if_vld) chk("if_adr", if_adr, exp_adr);
        if (resp_due && !jv) sb.push_back(ent_t'{exp_radr, mem(exp_radr)});
        if (jv) begin
            sb.delete();
        end else if (id_vld && dr) begin
            if (sb.size() == 0) begin
                chk("pop_on_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("id_pc", id_pc, e.pc);
                chk("id_ins", id_ins, e.ins);
                if (want_vld) begin
                    chk("redir_pc", id_pc, want_pc);
                    want_vld = 0;
                end
                if (first_id < 0) first_id = cyc_n;
            end
        end
        if (if_vld && ir) begin
            resp_due = 1;
            slv_adr  = if_adr;
            exp_radr = exp_adr;
            exp_fpc  = exp_adr + 32'd4;
            if (first_acc < 0) first_acc = cyc_n;
        end else begin
            resp_due = 0;
            if (jv) exp_fpc = {ja[31:2], 2'b00};
        end
        run_m = 1;
        cyc_n++;
        @(negedge clk);
    endtask

    // Called at a negedge; asserts reset asynchronously and releases it two cycles later.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_if_vld", if_vld, 0);
        chk("rst_id_vld", id_vld, 0);
        chk("rst_cnt", cnt, 0);
        sb.delete();
        resp_due  = 0;
        run_m     = 0;
        exp_fpc   = PC0;
        first_acc = -1;
        first_id  = -1;
        cyc_n     = 0;
        want_vld  = 0;
        jmp_vld   = 0;
        jmp_adr   = '0;
        if_rdy    = 1;
        id_rdy    = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill(input int budget);
        int k;
        k = 0;
        while (cnt != 2'd2 && k < budget) begin
            cyc(0, '0, 1, 0);
            k++;
        end
        chk("fill_cnt", cnt, 2);
    endtask

    initial begin
        jmp_vld = 0; jmp_adr = '0; if_rdy = 1; id_rdy = 1; if_rdt = '0;
        @(negedge clk);
        do_reset();

        // Streaming from the reset vector.
        for (int i = 0; i < 20; i++) cyc(0, '0, 1, 1);
        chk("first_acc_cycle", first_acc, 1);
`ifdef R5P_IFU_BYPASS_EN
        chk("fetch_to_id_latency", first_id - first_acc, 1);
`else
        chk("fetch_to_id_latency", first_id - first_acc, 2);
`endif

        // Decoder stalled: queue fills, issue stops; one pop frees one slot.
        fill(10);
        chk("full_if_vld", if_vld, 0);
        chk("full_id_vld", id_vld, 1);
        cyc(0, '0, 1, 1);
        chk("pop1_cnt", cnt, 1);
        chk("pop1_if_vld", if_vld, 1);
        for (int i = 0; i < 6; i++) cyc(0, '0, 1, 1);

        // Bus stall: request held, queue drains, then fetch resumes in order.
        for (int i = 0; i < 4; i++) begin
            cyc(0, '0, 0, 1);
            chk("stall_hold", if_vld, 1);
        end
        chk("stall_drained", id_vld, 0);
        for (int i = 0; i < 10; i++) cyc(0, '0, 1, 1);

        // Redirect with a response in flight.
        for (int i = 0; i < 10 && !resp_due; i++) cyc(0, '0, 1, 1);
        chk("resp_in_flight", resp_due, 1);
        want_vld = 1; want_pc = 32'h200;
        cyc(1, 32'h203, 1, 1);
        chk("redir_cnt", cnt, 0);
        for (int i = 0; i < 6; i++) cyc(0, '0, 1, 1);
        chk("redir_seen", want_vld, 0);

        // Back-to-back redirects: the second wins.
        want_vld = 1; want_pc = 32'h404;
        cyc(1, 32'h300, 1, 1);
        cyc(1, 32'h404, 1, 1);
        for (int i = 0; i < 6; i++) cyc(0, '0, 1, 1);
        chk("b2b_seen", want_vld, 0);

        // Redirect while stalled on if_rdy replaces the address.
        want_vld = 1; want_pc = 32'h50C;
        cyc(0, '0, 0, 1);
        cyc(1, 32'h50D, 0, 1);
        cyc(0, '0, 0, 1);
        for (int i = 0; i < 6; i++) cyc(0, '0, 1, 1);
        chk("stall_redir_seen", want_vld, 0);

        // Fetch pointer wraps past the top of the address space.
        want_vld = 1; want_pc = 32'hFFFF_FFFC;
        cyc(1, 32'hFFFF_FFFE, 1, 1);
        for (int i = 0; i < 8; i++) cyc(0, '0, 1, 1);
        chk("wrap_seen", want_vld, 0);

        // Reset while the queue is full.
        fill(10);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, '0, 1, 1);
        chk("rst_first_acc", first_acc, 1);

        // Random traffic.
        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
